// File: rtl/instr_loader_pkg.sv
// Shared constants for the instruction loader: word geometry, default address
// width and the loader FSM state encoding.
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes little-endian into one instruction word; byte k of a
// word is inserted at bits [8k+7:8k].
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               full
);

    logic [BYTE_CNT_W-1:0] byte_cnt;

    // NOTE: non-blocking assignments keep byte_cnt's old value for the insert
    // position in the same clock, so the counter and the slot stay in step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (load) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt                      <= byte_cnt + 1'b1;
        end
    end

    // The counter wraps to zero on the completing byte, ready for the next word.
    assign full = (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Program loader: byte stream in, one instruction-memory write per assembled
// word at word addresses 0..last_addr, CPU held while loading.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last;
    logic              accept_start;
    logic              transfer;
    logic              word_full;

    assign accept_start = start && (state == ST_IDLE || state == ST_DONE);
    assign transfer     = byte_valid && byte_ready;

    word_assembler u_word_assembler (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_start),
        .load    (transfer),
        .byte_in (byte_in),
        .word    (mem_wdata),
        .full    (word_full)
    );

    // Final address is compared before incrementing, so addr never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            addr  <= '0;
            last  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_COLLECT;
                        addr  <= '0;
                        last  <= last_addr;
                    end
                end
                ST_COLLECT: begin
                    if (transfer && word_full) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (addr == last) begin
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode the state register only; byte_ready never sees byte_valid.
    assign byte_ready = (state == ST_COLLECT);
    assign mem_we     = (state == ST_WRITE);
    assign cpu_hold   = (state == ST_COLLECT) || (state == ST_WRITE);
    assign done       = (state == ST_DONE);
    assign mem_addr   = addr;

endmodule

// File: tb/tb_instr_loader.sv
// Randomised self-checking bench for instr_loader against a byte-queue model
// of the little-endian load stream.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  last_addr;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;

    int checks = 0;
    int failures = 0;
    int write_count = 0;
    logic [7:0] byte_q[$];

    instr_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .last_addr  (last_addr),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) write_count++;

    function automatic logic [31:0] exp_word(input int w);
        return {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
    endfunction

    task automatic fill_random(input int n_words);
        byte_q.delete();
        for (int i = 0; i < 4 * n_words; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Drives one complete load of byte_q and checks every cycle until DONE.
    task automatic do_load(input int n_words, input bit stall, input bit poke, output int cyc);
        int k = 0;
        int w = 0;
        bit expect_write = 0;
        bit was_write;
        bit v;
        write_count = 0;
        start = 1'b1;
        last_addr = 8'(n_words - 1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (w < n_words && cyc < 20 * n_words + 20) begin
            if (expect_write) begin
                checks++;
                if ({mem_we, byte_ready, cpu_hold, done} !== 4'b1010 || mem_addr !== 8'(w)
                    || mem_wdata !== exp_word(w)) begin
                    failures++;
                    $display("FAIL write_cycle w=%0d: we/rdy/hold/done=%b addr=%h data=%h, want 1010 addr=%h data=%h",
                             w, {mem_we, byte_ready, cpu_hold, done}, mem_addr, mem_wdata, 8'(w), exp_word(w));
                end
                if (!stall) begin
                    checks++;
                    if (cyc != 5 * (w + 1)) begin
                        failures++;
                        $display("FAIL write_timing w=%0d: cycle %0d, want %0d", w, cyc, 5 * (w + 1));
                    end
                end
                w++;
                v = 1'b0;
                byte_valid = 1'($urandom_range(0, 1));
                byte_in = 8'($urandom_range(0, 255));
            end else begin
                checks++;
                if ({mem_we, byte_ready, cpu_hold, done} !== 4'b0110) begin
                    failures++;
                    $display("FAIL collect_flags cyc=%0d: we/rdy/hold/done=%b, want 0110",
                             cyc, {mem_we, byte_ready, cpu_hold, done});
                end
                v = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
                byte_valid = v;
                byte_in = v ? byte_q[k] : 8'($urandom_range(0, 255));
            end
            if (poke && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                last_addr = 8'($urandom_range(0, 255));
            end
            was_write = expect_write;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (was_write) expect_write = 0;
            else if (v) begin
                k++;
                expect_write = (k % 4 == 0);
            end
        end
        byte_valid = 1'b0;
        if (w < n_words) begin
            checks++;
            failures++;
            $display("FAIL load_timeout: wrote %0d words, want %0d", w, n_words);
        end
        checks++;
        if ({mem_we, byte_ready, cpu_hold, done} !== 4'b0001 || write_count != n_words) begin
            failures++;
            $display("FAIL done_state: we/rdy/hold/done=%b writes=%0d, want 0001 writes=%0d",
                     {mem_we, byte_ready, cpu_hold, done}, write_count, n_words);
        end
    endtask

    task automatic test_reset;
        int cyc;
        @(posedge clk); #1;
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done} !== '0) begin
            failures++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h hold=%b done=%b, want all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        last_addr = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'hAA;
        @(posedge clk); #1;
        byte_in = 8'hBB;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL mid_load_hold: cpu_hold=%b, want 1", cpu_hold);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done} !== '0) begin
            failures++;
            $display("FAIL async_reset: rdy=%b we=%b addr=%h data=%h hold=%b done=%b, want all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        fill_random(1);
        do_load(1, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_single_word;
        int cyc;
        byte_q = '{8'h13, 8'h00, 8'hA0, 8'hE3};
        do_load(1, 1'b0, 1'b0, cyc);
        checks++;
        if (mem_wdata !== 32'hE3A00013 || cyc != 6) begin
            failures++;
            $display("FAIL single_word: data=%h done_cycle=%0d, want E3A00013 at 6", mem_wdata, cyc);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        fill_random(3);
        do_load(3, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc != 16) begin
            failures++;
            $display("FAIL back_to_back_done: cycle %0d, want 16", cyc);
        end
    endtask

    task automatic test_stalled;
        int cyc;
        for (int r = 0; r < 3; r++) begin
            fill_random(2 + r);
            do_load(2 + r, 1'b1, 1'b0, cyc);
        end
    endtask

    task automatic test_ignored;
        int cyc;
        fill_random(4);
        do_load(4, 1'b1, 1'b1, cyc);
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_in = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            checks++;
            if ({mem_we, byte_ready, cpu_hold, done} !== 4'b0001 || mem_addr !== 8'd3 || write_count != 4) begin
                failures++;
                $display("FAIL ignored_in_done: flags=%b addr=%h writes=%0d, want 0001 addr=03 writes=4",
                         {mem_we, byte_ready, cpu_hold, done}, mem_addr, write_count);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_full_memory;
        int cyc;
        fill_random(256);
        do_load(256, 1'b0, 1'b0, cyc);
        byte_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        checks++;
        if (write_count != 256 || mem_addr !== 8'hFF || done !== 1'b1 || cyc != 5 * 256 + 1) begin
            failures++;
            $display("FAIL full_memory: writes=%0d addr=%h done=%b cycle=%0d, want 256 FF 1 %0d",
                     write_count, mem_addr, done, cyc, 5 * 256 + 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        last_addr = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stalled();
        test_ignored();
        test_full_memory();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes instruction words into the CPU instruction memory, the write-side counterpart of the read-only `instr_memory` fetch port. It accepts a byte stream over a valid/ready handshake, assembles bytes little-endian into 32-bit instructions, and issues one write per word at incrementing word addresses starting at 0. While loading it holds the CPU in reset/stall via `cpu_hold`; on completion it raises `done`.

## Interface

- `ADDR_W`, 8, instruction memory address width (word addresses, matches fetch address width).
- `DATA_W`, 32, instruction width; fixed at 4 bytes.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE.
- `last_addr`  in  ADDR_W  word address of final word to load; sampled on accepted `start`.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  instruction memory write enable, one cycle per word.
- `mem_addr`  out  ADDR_W  word write address.
- `mem_wdata`  out  DATA_W  assembled instruction.
- `cpu_hold`  out  1  high while loading (COLLECT or WRITE).
- `done`  out  1  high in DONE until next accepted `start`.

## Operation

- States: IDLE, COLLECT, WRITE, DONE. Reset → IDLE.
- IDLE: `start` → COLLECT; `addr`←0, `byte_cnt`←0, `last`←`last_addr`.
- COLLECT: `byte_ready`=1. Transfer when `byte_valid && byte_ready`. Byte k (k=0..3) lands in `wdata[8k+7:8k]` (first byte = LSB). `byte_cnt` increments per transfer; on transfer with `byte_cnt`==3 → WRITE, `byte_cnt`←0. No transfer → hold.
- WRITE: `mem_we`=1, `mem_addr`=`addr`, `mem_wdata`=assembled word, `byte_ready`=0. Next: if `addr`==`last` → DONE; else `addr`←`addr`+1 → COLLECT.
- DONE: `done`=1, `cpu_hold`=0. `start` → COLLECT with fresh `last_addr` and `addr`←0.
- `start` in COLLECT/WRITE ignored. `byte_valid` outside COLLECT ignored (not consumed).
- `last_addr`=2^ADDR_W−1 loads full memory; `addr` never wraps (DONE reached before increment).
- Reset mid-load: immediate return to IDLE, partial word discarded, words already written remain in memory.

## Timing

- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0.
- All outputs registered or decoded from state register only; no combinational path from `byte_valid` to `byte_ready`.
- `start` at edge n → `byte_ready`/`cpu_hold` high from cycle n+1.
- 4th byte accepted at edge m → `mem_we` high during cycle m+1 exactly one cycle; `byte_ready` low during that cycle.
- Back-to-back valid stream: 5 cycles per word; N words → `done` rises 5N+1 cycles after `start`.
- `mem_addr`/`mem_wdata` stable throughout the `mem_we` cycle; values outside WRITE are don't-care but hold last written.

## Structure

- Shared package: state encoding (IDLE/COLLECT/WRITE/DONE), `BYTES_PER_WORD`=4, `INSTR_W`=32, default `ADDR_W`.
- One sub-module natural: `word_assembler` (byte counter + 32-bit little-endian shift/insert register with `load`, `clear`, `full` outputs); FSM and address counter in top.

## Test plan

- Reset: assert `rst` mid-COLLECT after 2 bytes → all outputs 0 asynchronously; after release, fresh `start` reloads address 0 with no leftover bytes.
- Single word: `last_addr`=0, bytes 0x13,0x00,0xA0,0xE3 → one `mem_we` pulse, `mem_addr`=0, `mem_wdata`=0xE3A00013, `done`=1 one cycle later.
- Three words back-to-back, `last_addr`=2, `byte_valid` held high → writes at addr 0,1,2 in cycles 5,10,15 after start; `done` at cycle 16; `cpu_hold` high cycles 1–15.
- Stalled stream: `byte_valid` toggled 1-0-0-1… → bytes consumed only on valid&ready; `mem_wdata` correct; `byte_ready` low only in WRITE.
- Ignored inputs: `start` pulsed during COLLECT and WRITE, `byte_valid` high in DONE → no restart, no extra writes, `addr` unchanged.
- Full memory: `last_addr`=0xFF → 256 writes, last at `mem_addr`=0xFF, no wrap write to 0x00, `done`=1.
